branch_predict_btb: RTL and testbench
=====================================

Name: branch_predict_btb

Overview:
- Parametrised successor to the combinational branch/jump detector.
- Classifies the fetched instruction as branch, jal or jalr, as the detector does. Adds a direct-mapped branch target buffer (BTB) whose entries each hold a 2-bit saturating counter.
- Produces a same-cycle taken/target prediction at IF. It is trained by resolved control-flow results from EX.
- Sits between the PC-select mux and the IF/ID register of the pipelined datapath.

Parameters:
- XLEN, 32, PC and target width.
- ENTRIES, 16, BTB depth. Must be a power of 2, ≥2. IDX_W = log2(ENTRIES).
- CNT_INIT_BR, 2'b10, counter value written when a taken branch is allocated.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch slot valid.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_inst  in  32  fetched instruction word.
- cf_class  out  2  classification of if_inst: 00 none, 01 branch, 10 jal, 11 jalr.
- pred_taken  out  1  predicted redirect.
- pred_target  out  XLEN  next-PC prediction.
- upd_valid  in  1  resolved control-flow update strobe from EX.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_class  in  2  class of the resolved instruction. Same encoding as cf_class.
- upd_taken  in  1  actual outcome. Ignored for jal/jalr, which are always taken.
- upd_target  in  XLEN  actual target.
- perf_lookups  out  32  count of valid control-flow lookups. Saturating.
- perf_hits  out  32  count of those lookups that hit. Saturating.

Behaviour:
- Reset:
  - Asynchronous and active-low (rst_n), single clock clk.
  - While rst_n=0, all entries are invalid, all counters are 0 and both perf counters are 0.
  - Outputs are combinational from state. During reset, pred_taken=0 and pred_target=if_pc+4.
- Classification (combinational), on opcode if_inst[6:0]:
  - 1100011 → 01 (branch).
  - 1101111 → 10 (jal).
  - 1100111 → 11 (jalr).
  - anything else → 00.
- Addressing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry fields: valid, tag, is_jump, target[XLEN], cnt[2].
- Lookup (0-cycle, combinational):
  - hit = valid & tag match at idx(if_pc).
  - pred_taken = if_valid & (cf_class≠00) & hit & (is_jump | cnt[1]).
  - pred_target = pred_taken ? entry.target : if_pc+4. The add is modulo 2^XLEN, so it wraps at the top of the address space.
- Update (registered on the clk edge when upd_valid=1; upd_class=00 leaves the table unchanged):
  - Hit, branch: cnt = cnt+1 saturating at 3 when taken; cnt = cnt-1 saturating at 0 when not taken. target is written only when taken.
  - Hit, jal/jalr: target ← upd_target, cnt ← 3, is_jump ← 1.
  - Miss, branch taken: allocate, overwriting any occupant. Set valid=1, tag, is_jump=0, target, cnt=CNT_INIT_BR.
  - Miss, branch not taken: no allocation, table unchanged.
  - Miss, jal/jalr: allocate with is_jump=1, cnt=3.
- Same-cycle update and lookup to the same idx: the lookup sees the pre-update contents. There is no bypass. The new contents are visible the following cycle.
- Perf counters:
  - perf_lookups increments when if_valid & cf_class≠00.
  - perf_hits increments when, additionally, hit=1.
  - Both hold at 32'hFFFF_FFFF; they never wrap.
- Reset asserted mid-operation clears everything immediately. The first update after release behaves as a miss.

Decomposition:
- Shared package (core defs) holds:
  - Opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111.
  - The 2-bit cf_class typedef and its enum values CF_NONE, CF_BR, CF_JAL, CF_JALR.
  - The counter constants SNT=0, WNT=1, WT=2, ST=3.
- One natural sub-module: cf_classify. It is the purely combinational opcode→cf_class decoder and is instantiated twice, once for the IF path and once for any decoded-class checking.
- The table is a flat register array inside the top module. Do not use an SRAM macro.

Test Plan:
- Reset, then lookup with if_pc=0x100, if_inst=0x00000063 (beq) → cf_class=01, pred_taken=0, pred_target=0x104, perf_lookups=1, perf_hits=0.
- Update pc=0x100, branch, taken, target 0x80; next cycle lookup 0x100 → pred_taken=1 (cnt=2), pred_target=0x80. Two not-taken updates → cnt=0, pred_taken=0, and target is retained.
- Four taken updates on one entry → cnt saturates at 3. A single not-taken → cnt=2, still predicts taken.
- jalr at 0x200 updated with target 0x400, then 0x500 → lookup predicts 0x500 regardless of cnt history. An aliasing pc=0x200+4*ENTRIES misses, then replaces the entry after its own jal update.
- Update and lookup of 0x300 in the same cycle → lookup sees the old, invalid entry (pred_taken=0). Next cycle pred_taken=1.
- Preload perf_hits near saturation via a force in the bench, plus repeated hits → holds at 0xFFFFFFFF. Asserting rst_n=0 mid-stream → all predictions drop to pc+4 asynchronously.

Source files
------------

// File: rtl/branch_predict_btb_pkg.sv
// Shared control-flow definitions for the IF-stage predictor.
// Opcodes, class encoding and 2-bit counter states.
package branch_predict_btb_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    CF_NONE = 2'b00,
    CF_BR   = 2'b01,
    CF_JAL  = 2'b10,
    CF_JALR = 2'b11
  } cf_class_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] cnt_step(
    input logic [1:0] c,
    input logic       up
  );
    logic [1:0] r;
    if (up) r = (c == ST)  ? ST  : c + 2'd1;
    else    r = (c == SNT) ? SNT : c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_btb_cf_classify.sv
// Opcode to control-flow class decoder.
// Purely combinational.
module branch_predict_btb_cf_classify
  import branch_predict_btb_pkg::*;
(
  input  logic [6:0] opcode,
  output cf_class_e  cls
);

  // Map the major opcode onto the 2-bit class
  always_comb begin
    cls = CF_NONE;
    unique case (1'b1)
      opcode == OPC_BRANCH: cls = CF_BR;
      opcode == OPC_JAL:    cls = CF_JAL;
      opcode == OPC_JALR:   cls = CF_JALR;
      default:              cls = CF_NONE;
    endcase
  end

endmodule

// File: rtl/branch_predict_btb.sv
// Branch/jump classifier with a direct-mapped BTB.
// Same-cycle prediction at IF, trained from EX.
module branch_predict_btb
  import branch_predict_btb_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         ENTRIES     = 16,
  parameter logic [1:0] CNT_INIT_BR = 2'b10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic [1:0]      cf_class,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_class,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_hits
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic             jump_q  [ENTRIES];
  logic             jump_d  [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_d   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic [1:0]       cnt_d   [ENTRIES];

  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_hits_q, perf_hits_d;

  cf_class_e if_cls;
  cf_class_e chk_cls;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic             upd_br, upd_jmp;
  logic [XLEN-1:0]  pc_plus4;
  logic             unused_bits;

  branch_predict_btb_cf_classify u_cls_if (
    .opcode (if_inst[6:0]),
    .cls    (if_cls)
  );

  // Second decode of the fetched word qualifies the perf counters
  branch_predict_btb_cf_classify u_cls_chk (
    .opcode (if_inst[6:0]),
    .cls    (chk_cls)
  );

  assign unused_bits = ^{upd_pc[1:0], if_inst[31:7]};

  assign cf_class = if_cls;
  assign l_idx    = if_pc[IDX_W+1:2];
  assign l_tag    = if_pc[XLEN-1:IDX_W+2];
  assign u_idx    = upd_pc[IDX_W+1:2];
  assign u_tag    = upd_pc[XLEN-1:IDX_W+2];
  assign pc_plus4 = if_pc + XLEN'(4);
  assign upd_br   = upd_class == CF_BR;
  assign upd_jmp  = upd_class == CF_JAL
                 || upd_class == CF_JALR;

  assign perf_lookups = perf_lookups_q;
  assign perf_hits    = perf_hits_q;

  // Lookup: reads pre-update state, no bypass from EX
  always_comb begin
    l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken = if_valid && (if_cls != CF_NONE) && l_hit
              && (jump_q[l_idx] || cnt_q[l_idx][1]);
    pred_target = pred_taken ? tgt_q[l_idx] : pc_plus4;
  end

  // Training: counter step on hits, allocation on taken misses
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    jump_d  = jump_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    if (upd_valid) begin
      unique case (1'b1)
        upd_br && u_hit: begin
          cnt_d[u_idx] = cnt_step(cnt_q[u_idx], upd_taken);
          if (upd_taken) tgt_d[u_idx] = upd_target;
        end
        upd_br && !u_hit && upd_taken: begin
          valid_d[u_idx] = 1'b1;
          tag_d[u_idx]   = u_tag;
          jump_d[u_idx]  = 1'b0;
          tgt_d[u_idx]   = upd_target;
          cnt_d[u_idx]   = CNT_INIT_BR;
        end
        upd_jmp: begin
          valid_d[u_idx] = 1'b1;
          tag_d[u_idx]   = u_tag;
          jump_d[u_idx]  = 1'b1;
          tgt_d[u_idx]   = upd_target;
          cnt_d[u_idx]   = ST;
        end
        default: ;
      endcase
    end
  end

  // Saturating lookup/hit counters
  always_comb begin
    perf_lookups_d = perf_lookups_q;
    perf_hits_d    = perf_hits_q;
    if (if_valid && chk_cls != CF_NONE) begin
      if (perf_lookups_q != '1)
        perf_lookups_d = perf_lookups_q + 32'd1;
      if (l_hit && perf_hits_q != '1)
        perf_hits_d = perf_hits_q + 32'd1;
    end
  end

  // Table and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        jump_q[i]  <= 1'b0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= SNT;
      end
      perf_lookups_q <= '0;
      perf_hits_q    <= '0;
    end else begin
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      jump_q         <= jump_d;
      tgt_q          <= tgt_d;
      cnt_q          <= cnt_d;
      perf_lookups_q <= perf_lookups_d;
      perf_hits_q    <= perf_hits_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_btb.sv
// Bench for branch_predict_btb.
// Per-scenario tasks with a queue of expected outputs.
module tb_branch_predict_btb;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_8067;
  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic        clk, rst_n;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic [1:0]  cf_class;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_class;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] perf_lookups, perf_hits;

  branch_predict_btb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .cf_class     (cf_class),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_class    (upd_class),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .perf_lookups (perf_lookups),
    .perf_hits    (perf_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          uv;
    logic [31:0] upc;
    logic [1:0]  ucls;
    bit          utk;
    logic [31:0] utgt;
    bit          lv;
    logic [31:0] lpc;
    logic [31:0] linst;
    logic [1:0]  ecls;
    bit          etk;
    logic [31:0] etgt;
    bit          ehit;
  } step_t;

  typedef struct {
    logic [1:0]  cls;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] lk;
    logic [31:0] hit;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_lk = 0;
  logic [31:0] exp_hit = 0;
  logic [1:0]  got_cls;
  logic        got_tk;
  logic [31:0] got_tgt, got_lk, got_hit;

  function automatic step_t U(
    logic [31:0] pc, logic [1:0] c,
    bit tk, logic [31:0] tgt
  );
    return step_t'{1'b1, pc, c, tk, tgt,
      1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h4, 1'b0};
  endfunction

  function automatic step_t L(
    logic [31:0] pc, logic [31:0] inst, logic [1:0] c,
    bit tk, logic [31:0] tgt, bit hit
  );
    return step_t'{1'b0, 32'h0, 2'b00, 1'b0, 32'h0,
      1'b1, pc, inst, c, tk, tgt, hit};
  endfunction

  // Drive one cycle from just after a negedge; return at next negedge
  task automatic run(input step_t s);
    upd_valid  = s.uv;
    upd_pc     = s.upc;
    upd_class  = s.ucls;
    upd_taken  = s.utk;
    upd_target = s.utgt;
    if_valid   = s.lv;
    if_pc      = s.lpc;
    if_inst    = s.linst;
    sb.push_back(exp_t'{s.ecls, s.etk, s.etgt, exp_lk, exp_hit});
    #1;
    got_cls = cf_class;
    got_tk  = pred_taken;
    got_tgt = pred_target;
    got_lk  = perf_lookups;
    got_hit = perf_hits;
    @(posedge clk);
    if (s.lv && s.ecls != 2'b00) begin
      if (exp_lk != 32'hFFFF_FFFF) exp_lk++;
      if (s.ehit && exp_hit != 32'hFFFF_FFFF) exp_hit++;
    end
    #1;
    upd_valid = 1'b0;
    if_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    upd_valid = 0; upd_pc = 0; upd_class = 0;
    upd_taken = 0; upd_target = 0;
    if_valid = 1'b1; if_pc = 32'h100; if_inst = BEQ;
    #12;
    n_chk += 4;
    if (pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL reset_taken got %b exp 0", pred_taken); end
    if (pred_target !== 32'h104) begin n_fail++;
      $display("FAIL reset_target got %h exp 104", pred_target); end
    if (perf_lookups !== 32'h0) begin n_fail++;
      $display("FAIL reset_lookups got %h exp 0", perf_lookups); end
    if (perf_hits !== 32'h0) begin n_fail++;
      $display("FAIL reset_hits got %h exp 0", perf_hits); end
    if_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_lk = 0; exp_hit = 0;
  endtask

  task automatic test_branch_train();
    step_t s[$];
    s = '{
      L(32'h100, BEQ, 2'b01, 0, 32'h104, 0),
      U(32'h100, 2'b01, 1, 32'h80),
      L(32'h100, BEQ, 2'b01, 1, 32'h80, 1),
      L(32'h100, ADDI, 2'b00, 0, 32'h104, 0),
      U(32'h100, 2'b01, 0, 32'h999),
      L(32'h100, BEQ, 2'b01, 0, 32'h104, 1),
      U(32'h100, 2'b01, 0, 32'h999),
      L(32'h100, BEQ, 2'b01, 0, 32'h104, 1)
    };
    foreach (s[i]) begin
      run(s[i]);
      e = sb.pop_front();
      n_chk += 5;
      if (got_cls !== e.cls) begin n_fail++; $display("FAIL train[%0d] class got %h exp %h", i, got_cls, e.cls); end
      if (got_tk !== e.tk) begin n_fail++; $display("FAIL train[%0d] taken got %b exp %b", i, got_tk, e.tk); end
      if (got_tgt !== e.tgt) begin n_fail++; $display("FAIL train[%0d] target got %h exp %h", i, got_tgt, e.tgt); end
      if (got_lk !== e.lk) begin n_fail++; $display("FAIL train[%0d] lookups got %h exp %h", i, got_lk, e.lk); end
      if (got_hit !== e.hit) begin n_fail++; $display("FAIL train[%0d] hits got %h exp %h", i, got_hit, e.hit); end
    end
    n_chk++;
    if (dut.tgt_q[0] !== 32'h80) begin n_fail++;
      $display("FAIL train_retain target got %h exp 80", dut.tgt_q[0]); end
  endtask

  task automatic test_saturate();
    step_t s[$];
    s = '{
      U(32'h144, 2'b01, 1, 32'h1000),
      U(32'h144, 2'b01, 1, 32'h1000),
      U(32'h144, 2'b01, 1, 32'h1000),
      U(32'h144, 2'b01, 1, 32'h1000),
      L(32'h144, BEQ, 2'b01, 1, 32'h1000, 1),
      U(32'h144, 2'b01, 0, 32'h0),
      L(32'h144, BEQ, 2'b01, 1, 32'h1000, 1),
      U(32'h144, 2'b01, 0, 32'h0),
      L(32'h144, BEQ, 2'b01, 0, 32'h148, 1)
    };
    foreach (s[i]) begin
      run(s[i]);
      e = sb.pop_front();
      n_chk += 5;
      if (got_cls !== e.cls) begin n_fail++; $display("FAIL sat[%0d] class got %h exp %h", i, got_cls, e.cls); end
      if (got_tk !== e.tk) begin n_fail++; $display("FAIL sat[%0d] taken got %b exp %b", i, got_tk, e.tk); end
      if (got_tgt !== e.tgt) begin n_fail++; $display("FAIL sat[%0d] target got %h exp %h", i, got_tgt, e.tgt); end
      if (got_lk !== e.lk) begin n_fail++; $display("FAIL sat[%0d] lookups got %h exp %h", i, got_lk, e.lk); end
      if (got_hit !== e.hit) begin n_fail++; $display("FAIL sat[%0d] hits got %h exp %h", i, got_hit, e.hit); end
    end
  endtask

  task automatic test_jump();
    step_t s[$];
    s = '{
      L(32'h200, JALR, 2'b11, 0, 32'h204, 0),
      U(32'h200, 2'b11, 0, 32'h400),
      U(32'h200, 2'b11, 0, 32'h500),
      L(32'h200, JALR, 2'b11, 1, 32'h500, 1),
      U(32'h200, 2'b01, 0, 32'h0),
      U(32'h200, 2'b01, 0, 32'h0),
      L(32'h200, JALR, 2'b11, 1, 32'h500, 1),
      L(32'h240, JAL, 2'b10, 0, 32'h244, 0),
      U(32'h240, 2'b10, 1, 32'h600),
      L(32'h240, JAL, 2'b10, 1, 32'h600, 1),
      L(32'h200, JALR, 2'b11, 0, 32'h204, 0),
      L(32'hFFFF_FFFC, BEQ, 2'b01, 0, 32'h0, 0)
    };
    foreach (s[i]) begin
      run(s[i]);
      e = sb.pop_front();
      n_chk += 5;
      if (got_cls !== e.cls) begin n_fail++; $display("FAIL jump[%0d] class got %h exp %h", i, got_cls, e.cls); end
      if (got_tk !== e.tk) begin n_fail++; $display("FAIL jump[%0d] taken got %b exp %b", i, got_tk, e.tk); end
      if (got_tgt !== e.tgt) begin n_fail++; $display("FAIL jump[%0d] target got %h exp %h", i, got_tgt, e.tgt); end
      if (got_lk !== e.lk) begin n_fail++; $display("FAIL jump[%0d] lookups got %h exp %h", i, got_lk, e.lk); end
      if (got_hit !== e.hit) begin n_fail++; $display("FAIL jump[%0d] hits got %h exp %h", i, got_hit, e.hit); end
    end
  endtask

  task automatic test_same_cycle();
    step_t s[$];
    step_t b;
    b = L(32'h300, BEQ, 2'b01, 0, 32'h304, 0);
    b.uv = 1; b.upc = 32'h300; b.ucls = 2'b01;
    b.utk = 1; b.utgt = 32'h700;
    s = '{
      b,
      L(32'h300, BEQ, 2'b01, 1, 32'h700, 1),
      U(32'h300, 2'b00, 1, 32'h900),
      L(32'h300, BEQ, 2'b01, 1, 32'h700, 1)
    };
    foreach (s[i]) begin
      run(s[i]);
      e = sb.pop_front();
      n_chk += 5;
      if (got_cls !== e.cls) begin n_fail++; $display("FAIL same[%0d] class got %h exp %h", i, got_cls, e.cls); end
      if (got_tk !== e.tk) begin n_fail++; $display("FAIL same[%0d] taken got %b exp %b", i, got_tk, e.tk); end
      if (got_tgt !== e.tgt) begin n_fail++; $display("FAIL same[%0d] target got %h exp %h", i, got_tgt, e.tgt); end
      if (got_lk !== e.lk) begin n_fail++; $display("FAIL same[%0d] lookups got %h exp %h", i, got_lk, e.lk); end
      if (got_hit !== e.hit) begin n_fail++; $display("FAIL same[%0d] hits got %h exp %h", i, got_hit, e.hit); end
    end
  endtask

  task automatic test_perf_sat();
    step_t s[$];
    force dut.perf_hits_d = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    release dut.perf_hits_d;
    @(negedge clk);
    exp_hit = 32'hFFFF_FFFD;
    s = '{
      L(32'h300, BEQ, 2'b01, 1, 32'h700, 1),
      L(32'h300, BEQ, 2'b01, 1, 32'h700, 1),
      L(32'h300, BEQ, 2'b01, 1, 32'h700, 1),
      L(32'h300, BEQ, 2'b01, 1, 32'h700, 1)
    };
    foreach (s[i]) begin
      run(s[i]);
      e = sb.pop_front();
      n_chk += 3;
      if (got_tk !== e.tk) begin n_fail++; $display("FAIL perf[%0d] taken got %b exp %b", i, got_tk, e.tk); end
      if (got_lk !== e.lk) begin n_fail++; $display("FAIL perf[%0d] lookups got %h exp %h", i, got_lk, e.lk); end
      if (got_hit !== e.hit) begin n_fail++; $display("FAIL perf[%0d] hits got %h exp %h", i, got_hit, e.hit); end
    end
    n_chk++;
    if (perf_hits !== 32'hFFFF_FFFF) begin n_fail++;
      $display("FAIL perf_hold hits got %h exp ffffffff", perf_hits); end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    if_valid = 1'b1; if_pc = 32'h300; if_inst = BEQ;
    #1;
    n_chk += 2;
    if (pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL mid_pre taken got %b exp 1", pred_taken); end
    if (pred_target !== 32'h700) begin n_fail++;
      $display("FAIL mid_pre target got %h exp 700", pred_target); end
    #1 rst_n = 1'b0;
    #1;
    n_chk += 4;
    if (pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL mid_rst taken got %b exp 0", pred_taken); end
    if (pred_target !== 32'h304) begin n_fail++;
      $display("FAIL mid_rst target got %h exp 304", pred_target); end
    if (perf_lookups !== 32'h0) begin n_fail++;
      $display("FAIL mid_rst lookups got %h exp 0", perf_lookups); end
    if (perf_hits !== 32'h0) begin n_fail++;
      $display("FAIL mid_rst hits got %h exp 0", perf_hits); end
    if_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_lk = 0; exp_hit = 0;
    s = '{
      U(32'h300, 2'b01, 1, 32'h800),
      L(32'h300, BEQ, 2'b01, 1, 32'h800, 1),
      U(32'h300, 2'b01, 0, 32'h0),
      L(32'h300, BEQ, 2'b01, 0, 32'h304, 1)
    };
    foreach (s[i]) begin
      run(s[i]);
      e = sb.pop_front();
      n_chk += 5;
      if (got_cls !== e.cls) begin n_fail++; $display("FAIL mid[%0d] class got %h exp %h", i, got_cls, e.cls); end
      if (got_tk !== e.tk) begin n_fail++; $display("FAIL mid[%0d] taken got %b exp %b", i, got_tk, e.tk); end
      if (got_tgt !== e.tgt) begin n_fail++; $display("FAIL mid[%0d] target got %h exp %h", i, got_tgt, e.tgt); end
      if (got_lk !== e.lk) begin n_fail++; $display("FAIL mid[%0d] lookups got %h exp %h", i, got_lk, e.lk); end
      if (got_hit !== e.hit) begin n_fail++; $display("FAIL mid[%0d] hits got %h exp %h", i, got_hit, e.hit); end
    end
  endtask

  initial begin
    test_reset();
    test_branch_train();
    test_saturate();
    test_jump();
    test_same_cycle();
    test_perf_sat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
